// File: rtl/pifo_req_dispatcher_pkg.sv
// Shared types for the PIFO request dispatcher: op and drop-code enums,
// the queued request record and the tree-to-lane mapping.
package pifo_dispatch_pkg;

  localparam int PTW_DEF      = 16;
  localparam int TREE_NUM_DEF = 8;
  localparam int TIDW_DEF     = $clog2(TREE_NUM_DEF);

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    DROP_NONE  = 2'b00,
    DROP_FULL  = 2'b01,
    DROP_EMPTY = 2'b10
  } drop_code_e;

  typedef struct packed {
    op_e                 op;
    logic [TIDW_DEF-1:0] tree_id;
    logic [PTW_DEF-1:0]  data;
  } req_t;

  function automatic int unsigned lane_of(input int unsigned tree_id, input int unsigned level);
    return tree_id % level;
  endfunction

endpackage

// File: rtl/pifo_req_dispatcher_if.sv
// Valid/ready request stream into the dispatcher; the master drives the
// request, the slave (dispatcher) returns ready.
interface pifo_req_dispatcher_if #(
  parameter int PTW  = 16,
  parameter int TIDW = 3
);
  logic            i_req_valid;
  logic            o_req_ready;
  logic            i_req_op;
  logic [TIDW-1:0] i_req_tree_id;
  logic [PTW-1:0]  i_req_data;

  modport master (
    output i_req_valid, i_req_op, i_req_tree_id, i_req_data,
    input  o_req_ready
  );

  modport slave (
    input  i_req_valid, i_req_op, i_req_tree_id, i_req_data,
    output o_req_ready
  );
endinterface

// File: rtl/pifo_req_dispatcher_fifo.sv
// Synchronous show-ahead FIFO with async active-high reset; pointers carry an
// extra wrap bit so full and empty are told apart without a counter.
module pifo_dispatch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_arst,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_wr;
  logic         w_rd;

  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rd_data = r_mem[r_rptr[AW-1:0]];

  // pointer update
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
    end else begin
      if (w_wr) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_rd) r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // storage write
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end
endmodule

// File: rtl/pifo_req_dispatcher.sv
// Ingress dispatcher in front of the PIFO: queues push/pop requests, rejects
// push-to-full / pop-from-empty, and issues one-cycle per-lane strobes.
// Optional counters are enabled with `define PIFO_DISPATCH_STATS_EN.
module pifo_req_dispatcher
  import pifo_dispatch_pkg::*;
#(
  parameter int PTW       = PTW_DEF,
  parameter int LEVEL     = 8,
  parameter int TREE_NUM  = TREE_NUM_DEF,
  parameter int TREE_CAP  = 510,
  parameter int INQ_DEPTH = 8,
  parameter int ISSUE_GAP = 2
) (
  input  logic                                     i_clk,
  input  logic                                     i_arst,
  pifo_req_dispatcher_if.slave                     req_if,
  input  logic [LEVEL-1:0]                         i_task_fifo_full,
  output logic [LEVEL-1:0]                         o_push,
  output logic [LEVEL-1:0]                         o_pop,
  output logic [LEVEL-1:0][$clog2(TREE_NUM)-1:0]   o_tree_id,
  output logic [LEVEL-1:0][PTW-1:0]                o_push_data,
  output logic                                     o_drop,
  output logic [1:0]                               o_drop_code,
  output logic                                     o_busy
`ifdef PIFO_DISPATCH_STATS_EN
  ,
  output logic [31:0]                              o_stat_push,
  output logic [31:0]                              o_stat_pop,
  output logic [31:0]                              o_stat_drop,
  output logic [31:0]                              o_stat_stall
`endif
);
  localparam int TIDW = $clog2(TREE_NUM);
  localparam int LW   = (LEVEL > 1) ? $clog2(LEVEL) : 1;
  localparam int OCW  = $clog2(TREE_CAP + 1);
  localparam int GW   = $clog2(ISSUE_GAP + 1);

  req_t                         w_wr_req;
  req_t                         w_head;
  logic [$bits(req_t)-1:0]      w_head_bits;
  logic                         w_wr_en;
  logic                         w_rd_en;
  logic                         w_full;
  logic                         w_empty;
  logic [LW-1:0]                w_lane;
  logic [OCW-1:0]               w_occ_head;
  logic                         w_issue;
  logic                         w_drop;
  logic                         w_stall;
  drop_code_e                   w_code;
  logic [LEVEL-1:0]             w_sel;

  logic [LEVEL-1:0]             r_push;
  logic [LEVEL-1:0]             r_pop;
  logic [LEVEL-1:0][TIDW-1:0]   r_tree_id;
  logic [LEVEL-1:0][PTW-1:0]    r_push_data;
  logic                         r_drop;
  drop_code_e                   r_drop_code;
  logic [OCW-1:0]               r_occ [TREE_NUM];
  logic [GW-1:0]                r_gap [LEVEL];

  assign w_wr_req.op      = op_e'(req_if.i_req_op);
  assign w_wr_req.tree_id = req_if.i_req_tree_id;
  assign w_wr_req.data    = req_if.i_req_data;
  assign w_wr_en          = req_if.i_req_valid && !w_full;
  assign req_if.o_req_ready = !w_full;
  assign o_busy           = !w_empty;

  pifo_dispatch_fifo #(
    .W     ($bits(req_t)),
    .DEPTH (INQ_DEPTH)
  ) u_inq (
    .i_clk     (i_clk),
    .i_arst    (i_arst),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_req),
    .i_rd_en   (w_rd_en),
    .o_rd_data (w_head_bits),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_head     = req_t'(w_head_bits);
  assign w_lane     = LW'(lane_of(32'(w_head.tree_id), 32'(LEVEL)));
  assign w_occ_head = r_occ[w_head.tree_id];
  assign w_rd_en    = w_issue || w_drop;

  // head decision; a blocked head is held, nothing behind it may pass
  always_comb begin
    w_issue = 1'b0;
    w_drop  = 1'b0;
    w_stall = 1'b0;
    w_code  = DROP_NONE;
    if (w_empty) begin
      w_issue = 1'b0;
    end else if ((r_gap[w_lane] != {GW{1'b0}}) || i_task_fifo_full[w_lane]) begin
      w_stall = 1'b1;
    end else if ((w_head.op == OP_PUSH) && (w_occ_head == OCW'(TREE_CAP))) begin
      w_drop = 1'b1;
      w_code = DROP_FULL;
    end else if ((w_head.op == OP_POP) && (w_occ_head == {OCW{1'b0}})) begin
      w_drop = 1'b1;
      w_code = DROP_EMPTY;
    end else begin
      w_issue = 1'b1;
    end
  end

  // one-hot lane select for the issuing head
  always_comb begin
    w_sel = {LEVEL{1'b0}};
    if (w_issue) begin
      w_sel[w_lane] = 1'b1;
    end else begin
      w_sel = {LEVEL{1'b0}};
    end
  end

  // per-lane strobes, data and sticky tree id
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_push      <= {LEVEL{1'b0}};
      r_pop       <= {LEVEL{1'b0}};
      r_tree_id   <= {(LEVEL*TIDW){1'b0}};
      r_push_data <= {(LEVEL*PTW){1'b0}};
    end else begin
      for (int l = 0; l < LEVEL; l++) begin
        r_push[l]      <= w_sel[l] && (w_head.op == OP_PUSH);
        r_pop[l]       <= w_sel[l] && (w_head.op == OP_POP);
        r_push_data[l] <= (w_sel[l] && (w_head.op == OP_PUSH)) ? w_head.data : {PTW{1'b0}};
        if (w_sel[l]) r_tree_id[l] <= w_head.tree_id;
      end
    end
  end

  // issue spacing per lane
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int l = 0; l < LEVEL; l++) r_gap[l] <= {GW{1'b0}};
    end else begin
      for (int l = 0; l < LEVEL; l++) begin
        if (w_sel[l]) r_gap[l] <= GW'(ISSUE_GAP - 1);
        else if (r_gap[l] != {GW{1'b0}}) r_gap[l] <= r_gap[l] - GW'(1);
      end
    end
  end

  // per-tree occupancy, moved only by issued requests
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int t = 0; t < TREE_NUM; t++) r_occ[t] <= {OCW{1'b0}};
    end else begin
      for (int t = 0; t < TREE_NUM; t++) begin
        if (w_issue && (w_head.tree_id == TIDW'(t))) begin
          if (w_head.op == OP_PUSH) r_occ[t] <= r_occ[t] + OCW'(1);
          else                      r_occ[t] <= r_occ[t] - OCW'(1);
        end
      end
    end
  end

  // drop pulse lines up with where the strobe would have been
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_drop      <= 1'b0;
      r_drop_code <= DROP_NONE;
    end else begin
      r_drop      <= w_drop;
      r_drop_code <= w_code;
    end
  end

  assign o_push      = r_push;
  assign o_pop       = r_pop;
  assign o_tree_id   = r_tree_id;
  assign o_push_data = r_push_data;
  assign o_drop      = r_drop;
  assign o_drop_code = r_drop_code;

`ifdef PIFO_DISPATCH_STATS_EN
  logic [31:0] r_stat_push;
  logic [31:0] r_stat_pop;
  logic [31:0] r_stat_drop;
  logic [31:0] r_stat_stall;

  // free-running event counters, wrapping modulo 2^32
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_stat_push  <= 32'd0;
      r_stat_pop   <= 32'd0;
      r_stat_drop  <= 32'd0;
      r_stat_stall <= 32'd0;
    end else begin
      if (w_issue && (w_head.op == OP_PUSH)) r_stat_push <= r_stat_push + 32'd1;
      if (w_issue && (w_head.op == OP_POP))  r_stat_pop  <= r_stat_pop + 32'd1;
      if (w_drop)  r_stat_drop  <= r_stat_drop + 32'd1;
      if (w_stall) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign o_stat_push  = r_stat_push;
  assign o_stat_pop   = r_stat_pop;
  assign o_stat_drop  = r_stat_drop;
  assign o_stat_stall = r_stat_stall;
`endif
endmodule

// File: tb/tb_pifo_req_dispatcher.sv
// Scoreboard bench for pifo_req_dispatcher: the driver queues expected lane
// events on accept, a negedge monitor pops and compares each DUT event.
module tb_pifo_req_dispatcher;
  import pifo_dispatch_pkg::*;

  localparam int LEVEL    = 8;
  localparam int TREE_NUM = 8;
  localparam int TREE_CAP = 510;
  localparam int GAP      = 2;

  logic                     clk = 1'b0;
  logic                     arst = 1'b1;
  logic [LEVEL-1:0]         tff;
  logic [LEVEL-1:0]         o_push;
  logic [LEVEL-1:0]         o_pop;
  logic [LEVEL-1:0][2:0]    o_tree_id;
  logic [LEVEL-1:0][15:0]   o_push_data;
  logic                     o_drop;
  logic [1:0]               o_drop_code;
  logic                     o_busy;

  pifo_req_dispatcher_if #(.PTW(16), .TIDW(3)) req_if ();

  pifo_req_dispatcher dut (
    .i_clk            (clk),
    .i_arst           (arst),
    .req_if           (req_if),
    .i_task_fifo_full (tff),
    .o_push           (o_push),
    .o_pop            (o_pop),
    .o_tree_id        (o_tree_id),
    .o_push_data      (o_push_data),
    .o_drop           (o_drop),
    .o_drop_code      (o_drop_code),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 push strobe, 1 pop strobe, 2 drop
  typedef struct {
    int kind;
    int lane;
    int tree;
    int data;
    int code;
    bit chk_cyc;
    int cyc;
    int gap;
  } ev_t;

  ev_t exp_q[$];
  int  occ [TREE_NUM];
  int  lane_last [LEVEL];
  int  tests = 0;
  int  fails = 0;
  int  ev_count = 0;
  int  last_ev = -100;

  task automatic check_eq(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int req);
    tests++;
    if (act < req) begin
      fails++;
      $display("FAIL %s: got %0d, expected at least %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int t = 0; t < TREE_NUM; t++) occ[t] = 0;
    for (int l = 0; l < LEVEL; l++) lane_last[l] = -100;
    last_ev = -100;
  endtask

  // reference behaviour: requests resolve in order, so accept-time state is enough
  task automatic model_accept(input int op, input int tree, input int data,
                              input bit chk, input int gap, input int acc);
    ev_t e;
    e.lane = tree % LEVEL; e.tree = tree; e.chk_cyc = chk; e.cyc = acc + 1;
    e.gap = gap; e.code = 0; e.data = 0;
    if (op == 0) begin
      if (occ[tree] == TREE_CAP) begin e.kind = 2; e.code = 1; end
      else begin occ[tree]++; e.kind = 0; e.data = data; end
    end else begin
      if (occ[tree] == 0) begin e.kind = 2; e.code = 2; end
      else begin occ[tree]--; e.kind = 1; end
    end
    exp_q.push_back(e);
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input int op, input int tree, input int data, input bit chk, input int gap);
    int w;
    int acc;
    w = 0;
    req_if.i_req_valid   = 1'b1;
    req_if.i_req_op      = op[0];
    req_if.i_req_tree_id = tree[2:0];
    req_if.i_req_data    = data[15:0];
    while (!req_if.o_req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!req_if.o_req_ready) begin
      check_eq("ready_timeout", 0, 1);
      req_if.i_req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      model_accept(op, tree, data, chk, gap, acc);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check_eq("drain", exp_q.size(), 0);
  endtask

  // monitor
  always @(negedge clk) begin : mon
    int  n;
    int  ln;
    int  kind;
    int  other_nz;
    ev_t e;
    if (!arst) begin
      n = $countones(o_push) + $countones(o_pop) + int'(o_drop);
      if (n != 0) begin
        ev_count++;
        kind = o_drop ? 2 : ((o_push != 8'd0) ? 0 : 1);
        ln = 0;
        for (int l = 0; l < LEVEL; l++) if (o_push[l] || o_pop[l]) ln = l;
        check_eq("single_event", n, 1);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_event_kind", kind, -1);
        end else begin
          e = exp_q.pop_front();
          check_eq("event_kind", kind, e.kind);
          if (e.kind == 2) begin
            check_eq("drop_code", int'(o_drop_code), e.code);
          end else begin
            other_nz = 0;
            for (int l = 0; l < LEVEL; l++) if (l != ln && o_push_data[l] != 16'd0) other_nz++;
            check_eq("lane", ln, e.lane);
            check_eq("tree_id", int'(o_tree_id[ln]), e.tree);
            check_eq("push_data", int'(o_push_data[ln]), e.data);
            check_eq("idle_lane_data", other_nz, 0);
            check_ge("lane_spacing", cyc - lane_last[ln], GAP);
            lane_last[ln] = cyc;
          end
          if (e.chk_cyc) check_eq("latency_cycle", cyc, e.cyc);
          if (e.gap != 0) check_eq("issue_gap", cyc - last_ev, e.gap);
        end
        last_ev = cyc;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    tff = 8'h00;
    req_if.i_req_valid   = 1'b0;
    req_if.i_req_op      = 1'b0;
    req_if.i_req_tree_id = 3'd0;
    req_if.i_req_data    = 16'd0;
    model_clear();
    arst = 1'b1;
    repeat (3) @(negedge clk);
    arst = 1'b0;

    // reset state
    check_eq("rst_ready", int'(req_if.o_req_ready), 1);
    check_eq("rst_busy", int'(o_busy), 0);
    check_eq("rst_push", int'(o_push), 0);
    check_eq("rst_pop", int'(o_pop), 0);
    check_eq("rst_tree_id", int'(o_tree_id), 0);
    check_eq("rst_push_data", int'(o_push_data != 128'd0), 0);
    check_eq("rst_drop", int'(o_drop), 0);
    check_eq("rst_drop_code", int'(o_drop_code), 0);

    // push tree 3, then two pops: first issues, second finds it empty
    send(0, 3, 16'h0005, 1'b1, 0);
    send(1, 3, 0, 1'b0, 0);
    send(1, 3, 0, 1'b0, 0);
    req_if.i_req_valid = 1'b0;
    drain();

    // pop from empty tree 5
    send(1, 5, 0, 1'b1, 0);
    req_if.i_req_valid = 1'b0;
    drain();
    check_eq("empty_pop_busy", int'(o_busy), 0);

    // fill tree 0 to capacity, overflow once, then pop
    for (int i = 0; i < 511; i++) send(0, 0, i + 1, 1'b0, 0);
    send(1, 0, 0, 1'b0, 0);
    req_if.i_req_valid = 1'b0;
    drain();

    // lane 2 backpressure with head-of-line blocking
    tff = 8'h04;
    send(0, 2, 16'h0202, 1'b0, 0);
    send(0, 4, 16'h0404, 1'b0, 1);
    send(0, 1, 16'h0101, 1'b0, 1);
    send(0, 3, 16'h0303, 1'b0, 1);
    send(0, 5, 16'h0505, 1'b0, 1);
    send(0, 6, 16'h0606, 1'b0, 1);
    send(0, 7, 16'h0707, 1'b0, 1);
    send(0, 0, 16'h0A0A, 1'b0, 1);
    req_if.i_req_valid = 1'b0;
    check_eq("full_ready_low", int'(req_if.o_req_ready), 0);
    cnt0 = ev_count;
    repeat (12) @(negedge clk);
    check_eq("stall_no_issue", ev_count, cnt0);
    check_eq("stall_busy", int'(o_busy), 1);
    tff = 8'h00;
    drain();

    // fresh start: back-to-back pushes to all trees, then pop each twice
    arst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    arst = 1'b0;
    for (int t = 0; t < TREE_NUM; t++) send(0, t, 16'h0100 + t, 1'b1, (t == 0) ? 0 : 1);
    req_if.i_req_valid = 1'b0;
    drain();
    for (int t = 0; t < TREE_NUM; t++) send(1, t, 0, 1'b0, 0);
    for (int t = 0; t < TREE_NUM; t++) send(1, t, 0, 1'b0, 0);
    req_if.i_req_valid = 1'b0;
    drain();

    // asynchronous reset with requests queued and a strobe in flight
    tff = 8'hC0;
    send(0, 7, 16'h0077, 1'b0, 0);
    for (int i = 0; i < 5; i++) send(0, 6, 16'h0060 + i, 1'b0, 0);
    req_if.i_req_valid = 1'b0;
    tff = 8'h40;
    @(posedge clk);
    #1;
    check_eq("inflight_strobe", int'(o_push[7]), 1);
    arst = 1'b1;
    #1;
    check_eq("arst_push", int'(o_push), 0);
    check_eq("arst_pop", int'(o_pop), 0);
    check_eq("arst_push_data", int'(o_push_data != 128'd0), 0);
    check_eq("arst_tree_id", int'(o_tree_id), 0);
    check_eq("arst_drop", int'(o_drop), 0);
    check_eq("arst_busy", int'(o_busy), 0);
    model_clear();
    @(negedge clk);
    arst = 1'b0;
    tff = 8'h00;
    check_eq("post_rst_ready", int'(req_if.o_req_ready), 1);
    send(1, 2, 0, 1'b1, 0);
    req_if.i_req_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
